scan_seq_det: RTL and testbench
===============================

SCAN_SEQ_DET -- requirements
Module: scan_seq_det

Interface
REQ-001 SHALL have parameter LEN, default 4: pattern length in bits, legal range 2..8.
REQ-002 SHALL have parameter PATTERN, default 4'b1011: LEN-bit target sequence; PATTERN[LEN-1] is the oldest bit.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CW, default 4: detection counter width, legal range 1..16.
REQ-005 SHALL have port n_clk  input  1  clock; all state SHALL update on the falling edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port a  input  1  serial data bit under test.
REQ-008 SHALL have port c  input  1  count enable; 1 = sample a this edge.
REQ-009 SHALL have port m  input  1  scan mode; 1 = scan shift, 0 = functional.
REQ-010 SHALL have port sdi  input  1  scan data in.
REQ-011 SHALL have port sdo  output  1  scan data out.
REQ-012 SHALL have port n  output  1  registered detect pulse.
REQ-013 SHALL have port cnt  output  CW  saturating detection count.
REQ-014 SHALL have port fill  output  F  valid-history bit count, F = $clog2(LEN+1).

Function
REQ-015 SHALL hold internal registers hist[LEN-1:0], fill[F-1:0], cnt[CW-1:0], n.
REQ-016 Functional shift (m=0, c=1): hist_nx = {hist[LEN-2:0], a}; fill_nx = min(fill+1, LEN).
REQ-017 det SHALL be true when fill_nx == LEN and hist_nx == PATTERN; n SHALL be registered det, high exactly one cycle after the edge that samples the final pattern bit.
REQ-018 On det, cnt SHALL increment by 1 and saturate at 2^CW-1; never wrap.
REQ-019 On det with OVERLAP=0, fill SHALL load 0 instead of fill_nx; hist SHALL still load hist_nx.
REQ-020 Hold (m=0, c=0): hist, fill, cnt SHALL hold; n SHALL load 0.
REQ-021 Scan vector SV = {fill, cnt, hist}, width W = F+CW+LEN; sdo SHALL equal SV[W-1] combinationally in every mode.
REQ-022 Scan shift (m=1): SV SHALL load {SV[W-2:0], sdi} each edge regardless of c; n SHALL load 0; no detection or counting.
REQ-023 Scan-loaded values SHALL be used unmodified on the next functional edge, including fill values above LEN; such values SHALL be treated as LEN.
REQ-024 Switching m between edges SHALL take effect on the next edge with no extra latency or lost bit.

Reset
REQ-025 rst=1 at a falling edge SHALL clear hist, fill, cnt and n to 0, so sdo=0; rst SHALL take priority over m and c.
REQ-026 Reset mid-sequence or mid-scan SHALL discard all partial history and shifted data; no detection SHALL be reported on the reset edge.

Verification
REQ-027 Defaults, after reset, c=1, m=0, a=1,0,1,1 -> n=1 for the cycle after the 4th edge only; cnt=1.
REQ-028 Defaults, a=1,0,1,1,0,1,1 -> n pulses after edges 4 and 7, cnt=2; same stimulus with OVERLAP=0 -> one pulse, cnt=1, fill=3 at end.
REQ-029 a=1,0 then c=0 for 3 cycles with a=1, then c=1 with a=1,1 -> no pulse while c=0; one pulse after the final edge; fill frozen at 2 while c=0.
REQ-030 CW=2, 1011 stream repeated overlapping (1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1) -> 5 pulses; cnt 1,2,3,3,3.
REQ-031 m=1, shift 11 bits so fill=4, cnt=0, hist=4'b0101; observe sdo replay of old SV over 11 edges; then m=0, c=1, a=1 -> hist=1011, n=1, cnt=1.
REQ-032 rst=1 asserted mid-scan and mid-pattern (after 1,0,1) -> next cycle hist=fill=cnt=0, n=0, sdo=0; following 1 -> no pulse.

Source files
------------

// File: rtl/scan_seq_det.sv
// -----------------------------------------------------------------------------
// scan_seq_det
//
// Serial sequence detector with a built-in scan chain. A LEN-bit history
// register collects the serial input `a` whenever `c` is high. When the history
// holds LEN valid bits equal to PATTERN, a one-cycle registered pulse appears
// on `n` and the saturating counter `cnt` increments. In scan mode (m=1) the
// whole state {fill, cnt, hist} is one shift register, fed from `sdi` and
// observed on `sdo`.
//
// All state updates on the FALLING edge of n_clk.
//
// Parameters
//   LEN      pattern length in bits (2..8)
//   PATTERN  target sequence, PATTERN[LEN-1] is the oldest bit
//   OVERLAP  1 = overlapping detection, 0 = restart after each hit
//   CW       detection counter width (1..16)
//
// Ports
//   n_clk  in   clock, falling-edge active
//   rst    in   synchronous active-high reset (beats m and c)
//   a      in   serial data bit under test
//   c      in   sample enable for a
//   m      in   scan mode: 1 = shift scan chain, 0 = functional
//   sdi    in   scan data in (enters at the LSB of hist)
//   sdo    out  scan data out, MSB of {fill, cnt, hist}, combinational
//   n      out  registered detect pulse
//   cnt    out  saturating detection count
//   fill   out  number of valid history bits
// -----------------------------------------------------------------------------
module scan_seq_det #(
    parameter int               LEN     = 4,
    parameter logic [LEN-1:0]   PATTERN = LEN'(4'b1011),
    parameter bit               OVERLAP = 1'b1,
    parameter int               CW      = 4,
    localparam int              F       = $clog2(LEN + 1)
) (
    input  logic          n_clk,
    input  logic          rst,
    input  logic          a,
    input  logic          c,
    input  logic          m,
    input  logic          sdi,
    output logic          sdo,
    output logic          n,
    output logic [CW-1:0] cnt,
    output logic [F-1:0]  fill
);

    localparam int             W       = F + CW + LEN;
    localparam logic [F-1:0]   LEN_F   = F'(LEN);
    localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

    // State registers
    logic [LEN-1:0] r_hist;
    logic [F-1:0]   r_fill;
    logic [CW-1:0]  r_cnt;
    logic           r_n;

    // Next-state and helper signals
    logic [W-1:0]   w_sv;
    logic [W-1:0]   w_sv_shift;
    logic [LEN-1:0] w_hist_shift;
    logic [F-1:0]   w_fill_eff;
    logic [F-1:0]   w_fill_inc;
    logic           w_det;
    logic [LEN-1:0] w_hist_nx;
    logic [F-1:0]   w_fill_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic           w_n_nx;

    // Scan vector: fill is the head of the chain, hist is the tail.
    assign w_sv       = {r_fill, r_cnt, r_hist};
    assign w_sv_shift = {w_sv[W-2:0], sdi};

    // A scan-loaded fill above LEN is treated as a full history.
    assign w_fill_eff   = (r_fill > LEN_F) ? LEN_F : r_fill;
    assign w_fill_inc   = (w_fill_eff == LEN_F) ? LEN_F : (w_fill_eff + F'(1));
    assign w_hist_shift = {r_hist[LEN-2:0], a};

    // Detection looks at the post-shift history so the pulse is registered
    // one cycle after the edge that samples the final pattern bit.
    assign w_det = !m && c && (w_fill_inc == LEN_F) && (w_hist_shift == PATTERN);

    always_comb begin
        w_hist_nx = r_hist;
        w_fill_nx = r_fill;
        w_cnt_nx  = r_cnt;
        w_n_nx    = 1'b0;

        if (m) begin
            {w_fill_nx, w_cnt_nx, w_hist_nx} = w_sv_shift;
        end else if (c) begin
            w_hist_nx = w_hist_shift;
            w_fill_nx = w_fill_inc;
            if (w_det) begin
                w_n_nx = 1'b1;
                if (r_cnt != CNT_MAX) begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
                // Non-overlapping: the matched bits may not seed the next hit.
                if (!OVERLAP) begin
                    w_fill_nx = '0;
                end
            end
        end
    end

    always_ff @(negedge n_clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
            r_n    <= 1'b0;
        end else begin
            r_hist <= w_hist_nx;
            r_fill <= w_fill_nx;
            r_cnt  <= w_cnt_nx;
            r_n    <= w_n_nx;
        end
    end

    assign sdo  = w_sv[W-1];
    assign n    = r_n;
    assign cnt  = r_cnt;
    assign fill = r_fill;

endmodule

// File: tb/tb_scan_seq_det.sv
// -----------------------------------------------------------------------------
// tb_scan_seq_det
//
// Three instances share the same stimulus:
//   dut0 default (LEN=4, 1011, overlapping, CW=4)
//   dut1 OVERLAP=0
//   dut2 CW=2
// Inputs are driven on the rising edge, state updates on the falling edge and
// outputs are sampled 1 time unit after the falling edge.
// -----------------------------------------------------------------------------
module tb_scan_seq_det;

    logic n_clk = 1'b0;
    always #5 n_clk = ~n_clk;

    logic rst = 1'b1;
    logic a   = 1'b0;
    logic c   = 1'b0;
    logic m   = 1'b0;
    logic sdi = 1'b0;

    logic       sdo0, n0;
    logic [3:0] cnt0;
    logic [2:0] fill0;
    logic       sdo1, n1;
    logic [3:0] cnt1;
    logic [2:0] fill1;
    logic       sdo2, n2;
    logic [1:0] cnt2;
    logic [2:0] fill2;

    scan_seq_det dut0 (
        .n_clk(n_clk), .rst(rst), .a(a), .c(c), .m(m), .sdi(sdi),
        .sdo(sdo0), .n(n0), .cnt(cnt0), .fill(fill0)
    );

    scan_seq_det #(.OVERLAP(1'b0)) dut1 (
        .n_clk(n_clk), .rst(rst), .a(a), .c(c), .m(m), .sdi(sdi),
        .sdo(sdo1), .n(n1), .cnt(cnt1), .fill(fill1)
    );

    scan_seq_det #(.CW(2)) dut2 (
        .n_clk(n_clk), .rst(rst), .a(a), .c(c), .m(m), .sdi(sdi),
        .sdo(sdo2), .n(n2), .cnt(cnt2), .fill(fill2)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    // ---------------------------------------------------------------- driver
    task automatic drive(input logic ir, input logic ia, input logic ic,
                         input logic im, input logic isdi);
        @(posedge n_clk);
        rst = ir;
        a   = ia;
        c   = ic;
        m   = im;
        sdi = isdi;
        @(negedge n_clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        do_reset();
        compared++; if (n0 !== 1'b0)    begin mismatched++; $display("FAIL reset_n0 got %0b want 0", n0); end
        compared++; if (cnt0 !== 4'd0)  begin mismatched++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
        compared++; if (fill0 !== 3'd0) begin mismatched++; $display("FAIL reset_fill0 got %0d want 0", fill0); end
        compared++; if (sdo0 !== 1'b0)  begin mismatched++; $display("FAIL reset_sdo0 got %0b want 0", sdo0); end
        compared++; if (sdo1 !== 1'b0 || n1 !== 1'b0) begin mismatched++; $display("FAIL reset_dut1 got sdo=%0b n=%0b want 0/0", sdo1, n1); end
        compared++; if (sdo2 !== 1'b0 || cnt2 !== 2'd0) begin mismatched++; $display("FAIL reset_dut2 got sdo=%0b cnt=%0d want 0/0", sdo2, cnt2); end
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({7'd0, (i == 3)});
            drive(1'b0, bits[3-i], 1'b1, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            compared++;
            if (n0 !== exp_v[0]) begin mismatched++; $display("FAIL basic_n edge%0d got %0b want %0b", i + 1, n0, exp_v[0]); end
        end
        compared++; if (cnt0 !== 4'd1) begin mismatched++; $display("FAIL basic_cnt got %0d want 1", cnt0); end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        compared++; if (n0 !== 1'b0) begin mismatched++; $display("FAIL basic_pulse_width got %0b want 0", n0); end
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        bits = 7'b1011011;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            // [0]=dut0, [1]=dut1 (non-overlap), [2]=dut2
            exp_q.push_back({5'd0, (i == 3 || i == 6), (i == 3), (i == 3 || i == 6)});
            drive(1'b0, bits[6-i], 1'b1, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            compared++;
            if ({n2, n1, n0} !== exp_v[2:0]) begin
                mismatched++;
                $display("FAIL overlap_n edge%0d got %03b want %03b", i + 1, {n2, n1, n0}, exp_v[2:0]);
            end
        end
        compared++; if (cnt0 !== 4'd2)  begin mismatched++; $display("FAIL overlap_cnt0 got %0d want 2", cnt0); end
        compared++; if (cnt1 !== 4'd1)  begin mismatched++; $display("FAIL nonoverlap_cnt1 got %0d want 1", cnt1); end
        compared++; if (fill1 !== 3'd3) begin mismatched++; $display("FAIL nonoverlap_fill1 got %0d want 3", fill1); end
    endtask

    task automatic test_hold();
        logic [6:0] a_seq;
        logic [6:0] c_seq;
        a_seq = 7'b1011111;
        c_seq = 7'b1100011;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({7'd0, (i == 6)});
            drive(1'b0, a_seq[6-i], c_seq[6-i], 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            compared++;
            if (n0 !== exp_v[0]) begin mismatched++; $display("FAIL hold_n edge%0d got %0b want %0b", i + 1, n0, exp_v[0]); end
            if (c_seq[6-i] == 1'b0) begin
                compared++;
                if (fill0 !== 3'd2) begin mismatched++; $display("FAIL hold_fill edge%0d got %0d want 2", i + 1, fill0); end
            end
        end
        compared++; if (cnt0 !== 4'd1) begin mismatched++; $display("FAIL hold_cnt got %0d want 1", cnt0); end
    endtask

    task automatic test_saturate();
        logic [15:0] bits;
        int          pulses;
        int          seen;
        bits   = 16'b1011011011011011;
        pulses = 0;
        seen   = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            logic hit;
            hit = (i >= 3) && ((i % 3) == 0);
            if (hit) pulses++;
            exp_q.push_back({4'd0, 2'((pulses > 3) ? 3 : pulses), 1'b0, hit});
            drive(1'b0, bits[15-i], 1'b1, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            if (n2 === 1'b1) seen++;
            compared++;
            if (n2 !== exp_v[0] || cnt2 !== exp_v[3:2]) begin
                mismatched++;
                $display("FAIL sat_dut2 edge%0d got n=%0b cnt=%0d want n=%0b cnt=%0d", i + 1, n2, cnt2, exp_v[0], exp_v[3:2]);
            end
        end
        compared++; if (seen != 5)     begin mismatched++; $display("FAIL sat_pulses got %0d want 5", seen); end
        compared++; if (cnt0 !== 4'd5) begin mismatched++; $display("FAIL sat_cnt0 got %0d want 5", cnt0); end
    endtask

    task automatic test_scan();
        logic [10:0] old_sv;
        logic [10:0] new_sv;
        old_sv = {3'd4, 4'd1, 4'b1011};
        new_sv = {3'd4, 4'd0, 4'b0101};
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back({7'd0, old_sv[10-i]});
            exp_v = exp_q.pop_front();
            compared++;
            if (sdo0 !== exp_v[0]) begin mismatched++; $display("FAIL scan_sdo bit%0d got %0b want %0b", i, sdo0, exp_v[0]); end
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, new_sv[10-i]);
            if (i == 0) begin
                compared++;
                if (n0 !== 1'b0) begin mismatched++; $display("FAIL scan_n got %0b want 0", n0); end
            end
        end
        compared++; if (fill0 !== 3'd4 || cnt0 !== 4'd0) begin mismatched++; $display("FAIL scan_load got fill=%0d cnt=%0d want 4/0", fill0, cnt0); end
        compared++; if (sdo0 !== 1'b1) begin mismatched++; $display("FAIL scan_sdo_after got %0b want 1", sdo0); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        compared++; if (n0 !== 1'b1)   begin mismatched++; $display("FAIL scan_then_det_n got %0b want 1", n0); end
        compared++; if (cnt0 !== 4'd1) begin mismatched++; $display("FAIL scan_then_det_cnt got %0d want 1", cnt0); end
    endtask

    task automatic test_scan_fill_over();
        logic [10:0] new_sv;
        new_sv = {3'd7, 4'd0, 4'b0101};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, new_sv[10-i]);
        end
        compared++; if (fill0 !== 3'd7) begin mismatched++; $display("FAIL fill_over_load got %0d want 7", fill0); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        compared++; if (n0 !== 1'b1 || fill0 !== 3'd4 || cnt0 !== 4'd1) begin
            mismatched++;
            $display("FAIL fill_over_det got n=%0b fill=%0d cnt=%0d want 1/4/1", n0, fill0, cnt0);
        end
    endtask

    task automatic test_reset_mid();
        // Continues from prior state: hist=1011, fill=4, cnt=1.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Without reset, this edge (a=1) would complete 1011.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        compared++; if (n0 !== 1'b0 || cnt0 !== 4'd0 || fill0 !== 3'd0 || sdo0 !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_pattern got n=%0b cnt=%0d fill=%0d sdo=%0b want 0/0/0/0", n0, cnt0, fill0, sdo0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        compared++; if (n0 !== 1'b0 || fill0 !== 3'd1) begin mismatched++; $display("FAIL rst_after_bit got n=%0b fill=%0d want 0/1", n0, fill0); end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        compared++; if (n0 !== 1'b0 || cnt0 !== 4'd0 || fill0 !== 3'd0 || sdo0 !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_scan got n=%0b cnt=%0d fill=%0d sdo=%0b want 0/0/0/0", n0, cnt0, fill0, sdo0);
        end
    endtask

    task automatic test_random();
        logic [3:0] mh;
        int         mf;
        int         mc;
        logic       en;
        logic       ra;
        logic       rc;
        mh = 4'd0;
        mf = 0;
        mc = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            ra = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 3) != 0);
            en = 1'b0;
            if (rc) begin
                mh = {mh[2:0], ra};
                mf = (mf < 4) ? mf + 1 : 4;
                if (mf == 4 && mh == 4'b1011) begin
                    en = 1'b1;
                    mc = (mc < 15) ? mc + 1 : 15;
                end
            end
            exp_q.push_back({3'd0, 4'(mc), en});
            drive(1'b0, ra, rc, 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            compared++;
            if (n0 !== exp_v[0] || cnt0 !== exp_v[4:1]) begin
                mismatched++;
                $display("FAIL random cyc%0d got n=%0b cnt=%0d want n=%0b cnt=%0d", i, n0, cnt0, exp_v[0], exp_v[4:1]);
            end
        end
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_hold();
        test_saturate();
        test_scan();
        test_scan_fill_over();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
